// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable and optional auto-scan.
// Scan mode, dwell counter and wrap pulse are compiled in only with DECODER_SCAN_SCAN_EN.
module decoder_scan #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8,
   localparam int OUT_W  = 1 << SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic               wrap_q, wrap_d;

`ifdef DECODER_SCAN_SCAN_EN
   logic [DWELL_W-1:0] cnt_q, cnt_d;
`else
   // mode and dwell have no function when scan is compiled out.
   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{mode, dwell};
`endif

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      y_d     = '0;
`ifdef DECODER_SCAN_SCAN_EN
      cnt_d   = cnt_q;
`endif

      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
`ifdef DECODER_SCAN_SCAN_EN
      end else if (mode) begin
         state_d = SCAN;
         if (state_q != SCAN) begin
            // Entry always restarts at line 0 and never flags a wrap.
            idx_d = '0;
            cnt_d = dwell;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = dwell;
            wrap_d = &idx_q;
         end
`endif
      end else begin
         state_d = DIRECT;
         idx_d   = sel;
      end

      if (state_d != IDLE) begin
         y_d[idx_d] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled on clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
`ifdef DECODER_SCAN_SCAN_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
`ifdef DECODER_SCAN_SCAN_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule
